// File: rtl/control_pkg.sv
// Shared opcode, funct7 and ALUOp encodings and the FSM state type
// for the registered decode-stage control unit.
package control_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [1:0] ALUOP_LDST   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct7 decode into the control bundle, with
// MUL/DIV and illegal-instruction flags.
module control_decode
   import control_pkg::*;
#(
   parameter int OP_W     = 7,
   parameter int ALUOP_W  = 2,
   parameter int ENABLE_M = 1
) (
   input  logic [OP_W-1:0]    op_i,
   input  logic [6:0]         funct7_i,
   output logic               reg_write_o,
   output logic               mem_to_reg_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               alu_src_o,
   output logic               branch_o,
   output logic               is_muldiv_o,
   output logic               is_illegal_o
);

   always_comb begin
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      alu_op_o     = '0;
      alu_src_o    = 1'b0;
      branch_o     = 1'b0;
      is_muldiv_o  = 1'b0;
      is_illegal_o = 1'b0;

      if (op_i == OP_W'(OPC_RTYPE)) begin
         if (funct7_i == FUNCT7_MULDIV) begin
            if (ENABLE_M != 0) is_muldiv_o  = 1'b1;
            else               is_illegal_o = 1'b1;
         end else begin
            reg_write_o = 1'b1;
            alu_op_o    = ALUOP_W'(ALUOP_RTYPE);
         end
      end else if (op_i == OP_W'(OPC_ITYPE)) begin
         reg_write_o = 1'b1;
         alu_op_o    = ALUOP_W'(ALUOP_ITYPE);
         alu_src_o   = 1'b1;
      end else if (op_i == OP_W'(OPC_LOAD)) begin
         reg_write_o  = 1'b1;
         mem_to_reg_o = 1'b1;
         mem_read_o   = 1'b1;
         alu_op_o     = ALUOP_W'(ALUOP_LDST);
         alu_src_o    = 1'b1;
      end else if (op_i == OP_W'(OPC_STORE)) begin
         mem_write_o = 1'b1;
         alu_op_o    = ALUOP_W'(ALUOP_LDST);
         alu_src_o   = 1'b1;
      end else if (op_i == OP_W'(OPC_BRANCH)) begin
         branch_o = 1'b1;
         alu_op_o = ALUOP_W'(ALUOP_BRANCH);
      end else begin
         is_illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/pipelined_control.sv
// Registered ID/EX control half: decodes the ID instruction, holds MUL/DIV
// in a counted BUSY state (busy_o stalls upstream), honours flush and stall.
module pipelined_control
   import control_pkg::*;
#(
   parameter int OP_W       = 7,
   parameter int ALUOP_W    = 2,
   parameter int ENABLE_M   = 1,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic               NoOp_i,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic [OP_W-1:0]    Op_i,
   input  logic [6:0]         Funct7_i,
   output logic               RegWrite_o,
   output logic               MemtoReg_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               ALUSrc_o,
   output logic               Branch_o,
   output logic               MulDiv_o,
   output logic               valid_o,
   output logic               illegal_o,
   output logic               busy_o
);

   typedef struct packed {
      logic               reg_write;
      logic               mem_to_reg;
      logic               mem_read;
      logic               mem_write;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               branch;
      logic               mul_div;
      logic               valid;
   } bundle_t;

   bundle_t    dec;
   logic       dec_muldiv;
   logic       dec_illegal;

   bundle_t    ctrl_q, ctrl_d;
   logic       illegal_q, illegal_d;
   state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   control_decode #(
      .OP_W     (OP_W),
      .ALUOP_W  (ALUOP_W),
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .op_i         (Op_i),
      .funct7_i     (Funct7_i),
      .reg_write_o  (dec.reg_write),
      .mem_to_reg_o (dec.mem_to_reg),
      .mem_read_o   (dec.mem_read),
      .mem_write_o  (dec.mem_write),
      .alu_op_o     (dec.alu_op),
      .alu_src_o    (dec.alu_src),
      .branch_o     (dec.branch),
      .is_muldiv_o  (dec_muldiv),
      .is_illegal_o (dec_illegal)
   );

   assign dec.mul_div = 1'b0;
   assign dec.valid   = 1'b1;

   always_comb begin
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      state_d   = state_q;
      cnt_d     = cnt_q;

      if (flush_i) begin
         ctrl_d    = '0;
         illegal_d = 1'b0;
         state_d   = ST_IDLE;
         cnt_d     = '0;
      end else if (!stall_i) begin
         ctrl_d    = '0;
         illegal_d = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (valid_i && !NoOp_i) begin
                  if (dec_muldiv) begin
                     state_d = ST_BUSY;
                     cnt_d   = CNT_W'(MULDIV_LAT - 1);
                  end else if (dec_illegal) begin
                     illegal_d = 1'b1;
                  end else begin
                     ctrl_d = dec;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  ctrl_d.reg_write = 1'b1;
                  ctrl_d.alu_op    = ALUOP_W'(ALUOP_RTYPE);
                  ctrl_d.mul_div   = 1'b1;
                  ctrl_d.valid     = 1'b1;
                  state_d          = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   assign RegWrite_o = ctrl_q.reg_write;
   assign MemtoReg_o = ctrl_q.mem_to_reg;
   assign MemRead_o  = ctrl_q.mem_read;
   assign MemWrite_o = ctrl_q.mem_write;
   assign ALUOp_o    = ctrl_q.alu_op;
   assign ALUSrc_o   = ctrl_q.alu_src;
   assign Branch_o   = ctrl_q.branch;
   assign MulDiv_o   = ctrl_q.mul_div;
   assign valid_o    = ctrl_q.valid;
   assign illegal_o  = illegal_q;
   assign busy_o     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_pipelined_control.sv
// Directed bench for pipelined_control: M-enabled instance (MULDIV_LAT=4)
// plus an ENABLE_M=0 instance sharing the same inputs.
module tb_pipelined_control;

   logic       clk = 1'b0;
   logic       rst, valid, noop, flush, stall;
   logic [6:0] op, f7;

   logic       rw1, m2r1, mr1, mw1, as1, br1, md1, v1, ill1, busy1;
   logic [1:0] aop1;
   logic       rw2, m2r2, mr2, mw2, as2, br2, md2, v2, ill2, busy2;
   logic [1:0] aop2;
   logic [9:0] obs1, obs2;

   int vec  = 0;
   int miss = 0;

   localparam logic [9:0] B_BUBBLE = 10'b0_0_0_0_00_0_0_0_0;
   localparam logic [9:0] B_RTYPE  = 10'b1_0_0_0_10_0_0_0_1;
   localparam logic [9:0] B_ITYPE  = 10'b1_0_0_0_11_1_0_0_1;
   localparam logic [9:0] B_LOAD   = 10'b1_1_1_0_00_1_0_0_1;
   localparam logic [9:0] B_STORE  = 10'b0_0_0_1_00_1_0_0_1;
   localparam logic [9:0] B_BRANCH = 10'b0_0_0_0_01_0_1_0_1;
   localparam logic [9:0] B_MULDIV = 10'b1_0_0_0_10_0_0_1_1;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

   always #5 clk = ~clk;

   pipelined_control #(
      .OP_W(7), .ALUOP_W(2), .ENABLE_M(1), .MULDIV_LAT(4), .CNT_W(8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .NoOp_i(noop), .flush_i(flush),
      .stall_i(stall), .Op_i(op), .Funct7_i(f7),
      .RegWrite_o(rw1), .MemtoReg_o(m2r1), .MemRead_o(mr1), .MemWrite_o(mw1),
      .ALUOp_o(aop1), .ALUSrc_o(as1), .Branch_o(br1), .MulDiv_o(md1),
      .valid_o(v1), .illegal_o(ill1), .busy_o(busy1)
   );

   pipelined_control #(
      .OP_W(7), .ALUOP_W(2), .ENABLE_M(0), .MULDIV_LAT(4), .CNT_W(8)
   ) dut_nom (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .NoOp_i(noop), .flush_i(flush),
      .stall_i(stall), .Op_i(op), .Funct7_i(f7),
      .RegWrite_o(rw2), .MemtoReg_o(m2r2), .MemRead_o(mr2), .MemWrite_o(mw2),
      .ALUOp_o(aop2), .ALUSrc_o(as2), .Branch_o(br2), .MulDiv_o(md2),
      .valid_o(v2), .illegal_o(ill2), .busy_o(busy2)
   );

   assign obs1 = {rw1, m2r1, mr1, mw1, aop1, as1, br1, md1, v1};
   assign obs2 = {rw2, m2r2, mr2, mw2, aop2, as2, br2, md2, v2};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] o, input logic [6:0] f);
      valid = v;
      op    = o;
      f7    = f;
   endtask

   task automatic test_reset();
      rst = 1'b1; noop = 1'b0; flush = 1'b0; stall = 1'b0;
      drive(1'b1, OP_R, 7'd0);
      tick(); tick();
      vec++;
      if (obs1 !== B_BUBBLE || ill1 !== 1'b0 || busy1 !== 1'b0) begin
         miss++;
         $display("FAIL reset: bundle=%b illegal=%b busy=%b, required bundle=%b illegal=0 busy=0",
                  obs1, ill1, busy1, B_BUBBLE);
      end
      rst = 1'b0;
      tick();
      vec++;
      if (obs1 !== B_RTYPE) begin
         miss++;
         $display("FAIL reset_release_rtype: bundle=%b required=%b", obs1, B_RTYPE);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [4];
      logic [9:0] exp [4];
      ops = '{OP_LD, OP_ST, OP_BR, OP_I};
      exp = '{B_LOAD, B_STORE, B_BRANCH, B_ITYPE};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ops[i], 7'd0);
         tick();
         vec++;
         if (obs1 !== exp[i]) begin
            miss++;
            $display("FAIL back_to_back[%0d]: bundle=%b required=%b", i, obs1, exp[i]);
         end
      end
   endtask

   task automatic test_muldiv();
      drive(1'b1, OP_R, 7'b0000001);
      tick();
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (busy1 !== 1'b1 || obs1 !== B_BUBBLE) begin
            miss++;
            $display("FAIL muldiv_busy[%0d]: busy=%b bundle=%b, required busy=1 bundle=%b",
                     i, busy1, obs1, B_BUBBLE);
         end
         tick();
      end
      vec++;
      if (obs1 !== B_MULDIV || busy1 !== 1'b0) begin
         miss++;
         $display("FAIL muldiv_result: bundle=%b busy=%b, required bundle=%b busy=0",
                  obs1, busy1, B_MULDIV);
      end
      drive(1'b1, OP_I, 7'd0);
      tick();
      vec++;
      if (obs1 !== B_ITYPE) begin
         miss++;
         $display("FAIL after_muldiv: bundle=%b required=%b", obs1, B_ITYPE);
      end
   endtask

   task automatic test_flush();
      logic saw_md = 1'b0;
      drive(1'b1, OP_R, 7'b0000001);
      tick();
      saw_md |= md1;
      tick();
      saw_md |= md1;
      vec++;
      if (busy1 !== 1'b1) begin
         miss++;
         $display("FAIL flush_pre_busy: busy=%b required=1", busy1);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vec++;
      if (busy1 !== 1'b0 || obs1 !== B_BUBBLE) begin
         miss++;
         $display("FAIL flush_kill: busy=%b bundle=%b, required busy=0 bundle=%b",
                  busy1, obs1, B_BUBBLE);
      end
      drive(1'b1, OP_ST, 7'd0);
      for (int i = 0; i < 6; i++) begin
         saw_md |= md1;
         tick();
         if (i == 0) begin
            vec++;
            if (obs1 !== B_STORE) begin
               miss++;
               $display("FAIL flush_next_decode: bundle=%b required=%b", obs1, B_STORE);
            end
         end
      end
      vec++;
      if (saw_md !== 1'b0) begin
         miss++;
         $display("FAIL flush_no_muldiv: MulDiv seen=%b required=0", saw_md);
      end
   endtask

   task automatic test_stall();
      drive(1'b1, OP_ST, 7'd0);
      tick();
      stall = 1'b1;
      drive(1'b1, OP_LD, 7'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         vec++;
         if (obs1 !== B_STORE) begin
            miss++;
            $display("FAIL stall_hold[%0d]: bundle=%b required=%b", i, obs1, B_STORE);
         end
      end
      stall = 1'b0;
      tick();
      vec++;
      if (obs1 !== B_LOAD) begin
         miss++;
         $display("FAIL stall_release: bundle=%b required=%b", obs1, B_LOAD);
      end
   endtask

   task automatic test_stall_busy();
      int busy_cycles = 0;
      drive(1'b1, OP_R, 7'b0000001);
      tick();
      if (busy1 === 1'b1) busy_cycles++;
      for (int k = 0; k < 20 && busy1 === 1'b1; k++) begin
         stall = (k < 3);
         tick();
         if (busy1 === 1'b1) busy_cycles++;
      end
      stall = 1'b0;
      vec++;
      if (busy_cycles != 7) begin
         miss++;
         $display("FAIL stall_busy_len: busy cycles=%0d required=7", busy_cycles);
      end
      vec++;
      if (obs1 !== B_MULDIV) begin
         miss++;
         $display("FAIL stall_busy_result: bundle=%b required=%b", obs1, B_MULDIV);
      end
      drive(1'b0, OP_R, 7'd0);
      tick();
   endtask

   task automatic test_illegal();
      drive(1'b1, OP_BAD, 7'd0);
      tick();
      vec++;
      if (ill1 !== 1'b1 || v1 !== 1'b0 || obs1 !== B_BUBBLE) begin
         miss++;
         $display("FAIL illegal_opcode: illegal=%b bundle=%b, required illegal=1 bundle=%b",
                  ill1, obs1, B_BUBBLE);
      end
      stall = 1'b1;
      drive(1'b0, OP_R, 7'd0);
      tick();
      stall = 1'b0;
      vec++;
      if (ill1 !== 1'b1) begin
         miss++;
         $display("FAIL illegal_stall_extend: illegal=%b required=1", ill1);
      end
      tick();
      vec++;
      if (ill1 !== 1'b0) begin
         miss++;
         $display("FAIL illegal_one_cycle: illegal=%b required=0", ill1);
      end
      drive(1'b1, OP_R, 7'b0000001);
      tick();
      vec++;
      if (ill2 !== 1'b1 || v2 !== 1'b0 || busy2 !== 1'b0) begin
         miss++;
         $display("FAIL nom_muldiv_illegal: illegal=%b valid=%b busy=%b, required 1/0/0",
                  ill2, v2, busy2);
      end
      drive(1'b0, OP_R, 7'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vec++;
      if (ill2 !== 1'b0 || busy1 !== 1'b0) begin
         miss++;
         $display("FAIL nom_illegal_clear: illegal=%b busy=%b required 0/0", ill2, busy1);
      end
   endtask

   task automatic test_noop();
      noop = 1'b1;
      drive(1'b1, OP_LD, 7'd0);
      tick();
      noop = 1'b0;
      vec++;
      if (obs1 !== B_BUBBLE || ill1 !== 1'b0) begin
         miss++;
         $display("FAIL noop_bubble: bundle=%b illegal=%b, required bundle=%b illegal=0",
                  obs1, ill1, B_BUBBLE);
      end
   endtask

   task automatic test_reset_in_busy();
      drive(1'b1, OP_R, 7'b0000001);
      tick();
      drive(1'b0, OP_R, 7'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec++;
      if (busy1 !== 1'b0 || obs1 !== B_BUBBLE) begin
         miss++;
         $display("FAIL reset_busy: busy=%b bundle=%b, required busy=0 bundle=%b",
                  busy1, obs1, B_BUBBLE);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vec++;
         if (obs1 !== B_BUBBLE) begin
            miss++;
            $display("FAIL reset_busy_no_bundle[%0d]: bundle=%b required=%b",
                     i, obs1, B_BUBBLE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_muldiv();
      test_flush();
      test_stall();
      test_stall_busy();
      test_illegal();
      test_noop();
      test_reset_in_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
